// File: rtl/grf_wq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_wq_pkg
// Purpose  : Shared types and constants for the GRF write queue.
// Revision : 1.0 - initial release
// ============================================================================
package grf_wq_pkg;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]                addr;
        logic [DEFAULT_DATA_W-1:0] data;
        logic [31:0]               pc;
    } grf_wq_entry_t;
endpackage
`default_nettype wire

// File: rtl/grf_wq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : grf_wq_fifo
// Purpose  : MDU result FIFO with squash-by-address and per-entry query match.
//            GRF_WRITE_QUEUE_FORWARD_EN exposes entry data ordered by age.
// Revision : 1.0 - initial release
// ============================================================================
module grf_wq_fifo
    import grf_wq_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic [4:0]                i_push_addr,
    input  logic [DATA_W-1:0]         i_push_data,
    input  logic [31:0]               i_push_pc,
    input  logic                      i_pop,
    input  logic [4:0]                i_squash_addr,
    input  logic [4:0]                i_q1_addr,
    input  logic [4:0]                i_q2_addr,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [4:0]                o_head_addr,
    output logic [DATA_W-1:0]         o_head_data,
    output logic [31:0]               o_head_pc,
`ifdef GRF_WRITE_QUEUE_FORWARD_EN
    output logic [DEPTH*DATA_W-1:0]   o_age_data,
`endif
    output logic [DEPTH-1:0]          o_q1_match,
    output logic [DEPTH-1:0]          o_q2_match
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [31:0]       r_pc   [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [4:0]        w_push_addr;

    // An MDU result arriving alongside a pipeline write to the same register
    // is older than that write, so it is squashed on entry.
    assign w_push_addr = (i_push_addr == i_squash_addr) ? REG_ZERO : i_push_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop)  r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_squash_addr != REG_ZERO && r_addr[i] == i_squash_addr)
                r_addr[i] <= REG_ZERO;
        end
        if (i_push) begin
            r_addr[r_tail] <= w_push_addr;
            r_data[r_tail] <= i_push_data;
            r_pc[r_tail]   <= i_push_pc;
        end
    end

    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_head_pc   = r_pc[r_head];

    // Entry k of the age view is the k-th oldest; higher k is younger.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [PW-1:0] w_idx;
        logic          w_live;
        assign w_idx  = r_head + PW'(k);
        assign w_live = CW'(k) < r_count;
        assign o_q1_match[k] = w_live && (i_q1_addr != REG_ZERO) && (r_addr[w_idx] == i_q1_addr);
        assign o_q2_match[k] = w_live && (i_q2_addr != REG_ZERO) && (r_addr[w_idx] == i_q2_addr);
`ifdef GRF_WRITE_QUEUE_FORWARD_EN
        assign o_age_data[k*DATA_W +: DATA_W] = r_data[w_idx];
`endif
    end
endmodule
`default_nettype wire

// File: rtl/grf_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : grf_write_queue
// Purpose  : Merges pipeline writeback and queued MDU results onto the single
//            register-file write port; answers two hazard queries per cycle.
//            Define GRF_WRITE_QUEUE_FORWARD_EN to build the forwarding muxes.
// Revision : 1.0 - initial release
// ============================================================================
module grf_write_queue
    import grf_wq_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             i_pipe_addr,
    input  logic [DATA_W-1:0]      i_pipe_data,
    input  logic [31:0]            i_pipe_pc,
    input  logic                   i_mdu_valid,
    output logic                   o_mdu_ready,
    input  logic [4:0]             i_mdu_addr,
    input  logic [DATA_W-1:0]      i_mdu_data,
    input  logic [31:0]            i_mdu_pc,
    output logic [4:0]             o_wr_addr,
    output logic [DATA_W-1:0]      o_wr_data,
    output logic [31:0]            o_wr_pc,
    input  logic [4:0]             i_q1_addr,
    input  logic [4:0]             i_q2_addr,
    output logic                   o_q1_pending,
    output logic                   o_q2_pending,
    output logic [DATA_W-1:0]      o_q1_data,
    output logic [DATA_W-1:0]      o_q2_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     w_count;
    logic              w_ready;
    logic              w_pipe_wr;
    logic              w_push;
    logic              w_pop;
    logic [4:0]        w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [31:0]       w_head_pc;
    logic [DEPTH-1:0]  w_q1_match;
    logic [DEPTH-1:0]  w_q2_match;
    logic [4:0]        r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [31:0]       r_wr_pc;
`ifdef GRF_WRITE_QUEUE_FORWARD_EN
    logic [DEPTH*DATA_W-1:0] w_age_data;
`endif

    // Readiness looks at occupancy only, so a full queue never accepts even
    // on a cycle where the head pops.
    assign w_ready   = !reset && (w_count < CW'(DEPTH));
    assign w_pipe_wr = (i_pipe_addr != REG_ZERO);
    assign w_push    = i_mdu_valid && w_ready && (i_mdu_addr != REG_ZERO);
    assign w_pop     = !w_pipe_wr && (w_count != '0);

    grf_wq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_addr   (i_mdu_addr),
        .i_push_data   (i_mdu_data),
        .i_push_pc     (i_mdu_pc),
        .i_pop         (w_pop),
        .i_squash_addr (i_pipe_addr),
        .i_q1_addr     (i_q1_addr),
        .i_q2_addr     (i_q2_addr),
        .o_count       (w_count),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_head_pc     (w_head_pc),
`ifdef GRF_WRITE_QUEUE_FORWARD_EN
        .o_age_data    (w_age_data),
`endif
        .o_q1_match    (w_q1_match),
        .o_q2_match    (w_q2_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr <= REG_ZERO;
            r_wr_data <= '0;
            r_wr_pc   <= '0;
        end else if (w_pipe_wr) begin
            r_wr_addr <= i_pipe_addr;
            r_wr_data <= i_pipe_data;
            r_wr_pc   <= i_pipe_pc;
        end else if (w_pop) begin
            r_wr_addr <= w_head_addr;
            r_wr_data <= w_head_data;
            r_wr_pc   <= w_head_pc;
        end else begin
            r_wr_addr <= REG_ZERO;
            r_wr_data <= '0;
            r_wr_pc   <= '0;
        end
    end

    // The write on wr_* is still in flight: the register file commits it at
    // the next edge but reads combinationally.
    assign o_q1_pending = (i_q1_addr != REG_ZERO) && ((i_q1_addr == r_wr_addr) || (|w_q1_match));
    assign o_q2_pending = (i_q2_addr != REG_ZERO) && ((i_q2_addr == r_wr_addr) || (|w_q2_match));

`ifdef GRF_WRITE_QUEUE_FORWARD_EN
    function automatic logic [DATA_W-1:0] f_youngest(
        input logic [4:0]              a,
        input logic [DEPTH-1:0]        m,
        input logic [4:0]              wa,
        input logic [DATA_W-1:0]       wd,
        input logic [DEPTH*DATA_W-1:0] ad
    );
        logic [DATA_W-1:0] d;
        d = '0;
        if (a != REG_ZERO && a == wa) d = wd;
        for (int k = 0; k < DEPTH; k++) begin
            if (m[k]) d = ad[k*DATA_W +: DATA_W];
        end
        return d;
    endfunction

    assign o_q1_data = f_youngest(i_q1_addr, w_q1_match, r_wr_addr, r_wr_data, w_age_data);
    assign o_q2_data = f_youngest(i_q2_addr, w_q2_match, r_wr_addr, r_wr_data, w_age_data);
`else
    assign o_q1_data = '0;
    assign o_q2_data = '0;
`endif

    assign o_mdu_ready = w_ready;
    assign o_count     = w_count;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_wr_pc     = r_wr_pc;
endmodule
`default_nettype wire

// File: tb/tb_grf_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_write_queue
// Purpose  : Self-checking bench for grf_write_queue (directed table, corner
//            sequences, randomized traffic against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_write_queue;
    import grf_wq_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    pipe_addr;
    logic [DW-1:0] pipe_data;
    logic [31:0]   pipe_pc;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [4:0]    mdu_addr;
    logic [DW-1:0] mdu_data;
    logic [31:0]   mdu_pc;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [31:0]   wr_pc;
    logic [4:0]    q1_addr, q2_addr;
    logic          q1_pending, q2_pending;
    logic [DW-1:0] q1_data, q2_data;
    logic [2:0]    count;

    always #5 clk = ~clk;

    grf_write_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .i_pipe_addr(pipe_addr), .i_pipe_data(pipe_data), .i_pipe_pc(pipe_pc),
        .i_mdu_valid(mdu_valid), .o_mdu_ready(mdu_ready),
        .i_mdu_addr(mdu_addr), .i_mdu_data(mdu_data), .i_mdu_pc(mdu_pc),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_wr_pc(wr_pc),
        .i_q1_addr(q1_addr), .i_q2_addr(q2_addr),
        .o_q1_pending(q1_pending), .o_q2_pending(q2_pending),
        .o_q1_data(q1_data), .o_q2_data(q2_data),
        .o_count(count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    grf_wq_entry_t q[$];
    logic [4:0]    m_wr_addr;
    logic [31:0]   m_wr_data, m_wr_pc;
    logic [31:0]   rf_dut [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (a == m_wr_addr) return 1'b1;
        foreach (q[i]) if (q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a);
        logic [31:0] d;
        d = 32'd0;
`ifdef GRF_WRITE_QUEUE_FORWARD_EN
        if (a != 5'd0) begin
            if (a == m_wr_addr) d = m_wr_data;
            foreach (q[i]) if (q[i].addr == a) d = q[i].data;
        end
`endif
        return d;
    endfunction

    // Advances the reference model across one clock edge using current inputs.
    function automatic void model_edge();
        grf_wq_entry_t e;
        logic acc;
        if (reset) begin
            q.delete();
            m_wr_addr = 5'd0; m_wr_data = 32'd0; m_wr_pc = 32'd0;
            return;
        end
        acc = mdu_valid && (q.size() < DEPTH);
        if (pipe_addr != 5'd0) begin
            foreach (q[i]) if (q[i].addr == pipe_addr) q[i].addr = 5'd0;
            m_wr_addr = pipe_addr; m_wr_data = pipe_data; m_wr_pc = pipe_pc;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_wr_addr = e.addr; m_wr_data = e.data; m_wr_pc = e.pc;
        end else begin
            m_wr_addr = 5'd0;
        end
        if (acc && mdu_addr != 5'd0) begin
            e.addr = (mdu_addr == pipe_addr) ? 5'd0 : mdu_addr;
            e.data = mdu_data;
            e.pc   = mdu_pc;
            q.push_back(e);
        end
    endfunction

    task automatic settle();
        #4;
        chk("ready", mdu_ready, (!reset && q.size() < DEPTH));
        chk("count", count, q.size());
        chk("wr_addr", wr_addr, m_wr_addr);
        if (m_wr_addr != 5'd0) begin
            chk("wr_data", wr_data, m_wr_data);
            chk("wr_pc", wr_pc, m_wr_pc);
        end
        chk("q1_pending", q1_pending, m_pend(q1_addr));
        chk("q2_pending", q2_pending, m_pend(q2_addr));
        chk("q1_data", q1_data, m_fwd(q1_addr));
        chk("q2_data", q2_data, m_fwd(q2_addr));
    endtask

    task automatic tick();
        if (wr_addr != 5'd0) rf_dut[wr_addr] = wr_data;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0; pipe_pc = 32'd0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0; mdu_pc = 32'd0;
    endtask

    typedef struct {
        logic        rst;
        logic [4:0]  pa;  logic [31:0] pd;  logic [31:0] pp;
        logic        mv;  logic [4:0]  ma;  logic [31:0] md; logic [31:0] mp;
        logic [4:0]  q1;  logic [4:0]  q2;
        logic [4:0]  e_wa; logic [31:0] e_wd; logic [31:0] e_wp;
        int          e_cnt;
        logic        e_rdy; logic e_p1; logic e_p2;
    } vec_t;

    vec_t tv [12];

    initial begin
        // rst pa pd pp | mv ma md mp | q1 q2 | wa wd wp cnt rdy p1 p2
        tv[0]  = '{1, 0, 0, 0,          0, 0, 0, 0,               0, 0, 0, 0, 0,                 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0,          0, 0, 0, 0,               5, 0, 0, 0, 0,                 0, 1, 0, 0};
        tv[2]  = '{0, 0, 0, 0,          1, 5, 32'h1234, 32'h3000, 5, 0, 0, 0, 0,                 0, 1, 0, 0};
        tv[3]  = '{0, 0, 0, 0,          0, 0, 0, 0,               5, 0, 0, 0, 0,                 1, 1, 1, 0};
        tv[4]  = '{0, 0, 0, 0,          0, 0, 0, 0,               5, 0, 5, 32'h1234, 32'h3000,   0, 1, 1, 0};
        tv[5]  = '{0, 0, 0, 0,          0, 0, 0, 0,               5, 0, 0, 0, 0,                 0, 1, 0, 0};
        tv[6]  = '{0, 9, 32'h99, 32'h5000, 1, 8, 32'h88, 32'h4000, 8, 9, 0, 0, 0,                0, 1, 0, 0};
        tv[7]  = '{0, 9, 32'h9A, 32'h5004, 0, 0, 0, 0,            8, 9, 9, 32'h99, 32'h5000,     1, 1, 1, 1};
        tv[8]  = '{0, 9, 32'h9B, 32'h5008, 0, 0, 0, 0,            8, 9, 9, 32'h9A, 32'h5004,     1, 1, 1, 1};
        tv[9]  = '{0, 0, 0, 0,          0, 0, 0, 0,               8, 9, 9, 32'h9B, 32'h5008,     1, 1, 1, 1};
        tv[10] = '{0, 0, 0, 0,          0, 0, 0, 0,               8, 9, 8, 32'h88, 32'h4000,     0, 1, 1, 0};
        tv[11] = '{0, 0, 0, 0,          0, 0, 0, 0,               8, 9, 0, 0, 0,                 0, 1, 0, 0};

        for (int r = 0; r < 32; r++) rf_dut[r] = 32'd0;
        idle_inputs();
        reset = 1'b1; q1_addr = 5'd0; q2_addr = 5'd0;
        @(posedge clk);
        #1;
        q.delete();
        m_wr_addr = 5'd0; m_wr_data = 32'd0; m_wr_pc = 32'd0;

        for (int i = 0; i < 12; i++) begin
            reset = tv[i].rst;
            pipe_addr = tv[i].pa; pipe_data = tv[i].pd; pipe_pc = tv[i].pp;
            mdu_valid = tv[i].mv; mdu_addr = tv[i].ma; mdu_data = tv[i].md; mdu_pc = tv[i].mp;
            q1_addr = tv[i].q1; q2_addr = tv[i].q2;
            settle();
            chk("tv_wr_addr", wr_addr, tv[i].e_wa);
            if (tv[i].e_wa != 5'd0) begin
                chk("tv_wr_data", wr_data, tv[i].e_wd);
                chk("tv_wr_pc", wr_pc, tv[i].e_wp);
            end
            chk("tv_count", count, tv[i].e_cnt);
            chk("tv_ready", mdu_ready, tv[i].e_rdy);
            chk("tv_q1_pending", q1_pending, tv[i].e_p1);
            chk("tv_q2_pending", q2_pending, tv[i].e_p2);
            tick();
        end

        // Fill under continuous pipeline writes, then drain in order.
        q1_addr = 5'd0; q2_addr = 5'd0;
        for (int i = 1; i <= 4; i++) begin
            idle_inputs();
            pipe_addr = 5'd20; pipe_data = 32'h2000 + i; pipe_pc = 32'h7000 + 4 * i;
            mdu_valid = 1'b1; mdu_addr = 5'(i); mdu_data = 32'h100 + i; mdu_pc = 32'h6000 + 4 * i;
            settle(); tick();
        end
        idle_inputs();
        pipe_addr = 5'd20; pipe_data = 32'h2005; mdu_valid = 1'b1; mdu_addr = 5'd5;
        settle();
        chk("full_ready", mdu_ready, 1'b0);
        chk("full_count", count, 3'd4);
        tick();
        idle_inputs();
        settle(); chk("drain_pre", wr_addr, 5'd20); tick();
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk("drain_addr", wr_addr, 5'(i));
            chk("drain_data", wr_data, 32'h100 + i);
            tick();
        end
        settle(); chk("drain_empty", count, 3'd0); tick();

        // Squash: queued r7 overwritten by a pipeline write to r7.
        idle_inputs();
        pipe_addr = 5'd10; pipe_data = 32'h10; mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hAAAA;
        settle(); tick();
        idle_inputs();
        pipe_addr = 5'd7; pipe_data = 32'hBBBB; pipe_pc = 32'h8000;
        settle(); tick();
        idle_inputs();
        settle();
        chk("squash_pipe_addr", wr_addr, 5'd7);
        chk("squash_pipe_data", wr_data, 32'hBBBB);
        chk("squash_cnt", count, 3'd1);
        tick();
        settle();
        chk("squash_idle_issue", wr_addr, 5'd0);
        chk("squash_cnt_after", count, 3'd0);
        tick();
        settle(); tick();
        chk("squash_rf_r7", rf_dut[7], 32'hBBBB);

        // Forwarding: two queued writes to r7, youngest must win.
        idle_inputs();
        q1_addr = 5'd7; q2_addr = 5'd0;
        pipe_addr = 5'd10; pipe_data = 32'h1010; mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h11;
        settle(); tick();
        mdu_data = 32'h22; pipe_data = 32'h1011;
        settle(); tick();
        mdu_valid = 1'b0; pipe_data = 32'h1012;
        settle();
        chk("fwd_q1_pending", q1_pending, 1'b1);
`ifdef GRF_WRITE_QUEUE_FORWARD_EN
        chk("fwd_q1_data", q1_data, 32'h22);
`else
        chk("fwd_q1_data", q1_data, 32'h0);
`endif
        chk("fwd_q2_pending", q2_pending, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin settle(); tick(); end

        // Reset with three entries queued.
        q1_addr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            pipe_addr = 5'd11; pipe_data = 32'h1100 + i;
            mdu_valid = 1'b1; mdu_addr = 5'(12 + i); mdu_data = 32'h1200 + i;
            settle(); tick();
        end
        idle_inputs();
        reset = 1'b1; mdu_valid = 1'b1; mdu_addr = 5'd15; mdu_data = 32'h15;
        settle();
        chk("rst_pre_count", count, 3'd3);
        chk("rst_ready", mdu_ready, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_count", count, 3'd0);
            chk("rst_wr_addr", wr_addr, 5'd0);
            tick();
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int busy_pct;
            busy_pct = ((i / 250) % 2 == 1) ? 80 : 25;
            reset     = ($urandom_range(0, 99) < 2);
            pipe_addr = ($urandom_range(0, 99) < busy_pct) ? 5'($urandom_range(1, 7)) : 5'd0;
            pipe_data = $urandom;
            pipe_pc   = $urandom;
            mdu_valid = 1'($urandom_range(0, 1));
            mdu_addr  = 5'($urandom_range(0, 7));
            mdu_data  = $urandom;
            mdu_pc    = $urandom;
            q1_addr   = 5'($urandom_range(0, 7));
            q2_addr   = 5'($urandom_range(0, 7));
            settle(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
